// File: rtl/disp_scan_mux.sv
// disp_scan_mux: 4-digit seven-segment scanner with a double-buffered value and leading-zero blanking
module disp_scan_mux #(
  parameter int DWELL = 50000,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] din,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  addr,
  output logic [3:0]  an,
  output logic        dp,
  output logic        pending,
  output logic        frame_done
);
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sel;
  logic [15:0]      active, shadow;
  logic [3:0]       active_dp, shadow_dp;
  logic [3:0]       blk;
  logic             last, boundary, commit;
  // slot timing, frame boundary and per-digit leading-zero blanking
  always_comb begin
    last     = cnt == CNT_W'(DWELL - 1);
    boundary = last && sel == 2'd3;
    commit   = boundary && (pending || load);
    blk      = {blank_lz && active[15:12] == 4'h0,
                blank_lz && active[15:8] == 8'h0,
                blank_lz && active[15:4] == 12'h0,
                1'b0};
    addr     = active[4*sel +: 4];
  end
  // scan counters, shadow/active buffers and drives registered one cycle behind addr
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      sel        <= '0;
      active     <= '0;
      active_dp  <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      an         <= 4'hf;
      dp         <= 1'b1;
    end else begin
      cnt        <= last ? '0 : cnt + 1'b1;
      sel        <= last ? sel + 2'd1 : sel;
      an         <= blk[sel] ? 4'hf : ~(4'b0001 << sel);
      dp         <= blk[sel] | ~active_dp[sel];
      frame_done <= commit;
      if (load) begin
        shadow    <= din;
        shadow_dp <= dp_in;
      end
      pending <= commit ? 1'b0 : (load ? 1'b1 : pending);
      if (commit) begin
        active    <= load ? din : shadow;
        active_dp <= load ? dp_in : shadow_dp;
      end
    end
  end
endmodule

// File: tb/tb_disp_scan_mux.sv
// tb_disp_scan_mux: directed stimulus with a cycle-level model and literal checkpoints
module tb_disp_scan_mux;
  logic        clk = 0, reset = 1, load = 0, blank_lz = 0;
  logic [15:0] din = 0;
  logic [3:0]  dp_in = 0;
  logic [3:0]  addr, an;
  logic        dp, pending, frame_done;
  int errors = 0, checks = 0;

  disp_scan_mux #(.DWELL(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .load(load), .din(din), .dp_in(dp_in),
    .blank_lz(blank_lz), .addr(addr), .an(an), .dp(dp),
    .pending(pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // model: time since reset defines slot and frame position
  int          m_t = 0;
  logic [15:0] m_active = 0, m_shadow = 0;
  logic [3:0]  m_adp = 0, m_sdp = 0, m_an = 4'hf;
  logic        m_dp = 1, m_pend = 0, m_fd = 0, go = 0;

  function automatic bit blanked(int k);
    return blank_lz && k > 0 && (m_active >> (4 * k)) == 16'h0;
  endfunction

  always @(posedge clk) begin
    int s;
    bit c, bl;
    go = 1;
    if (reset) begin
      m_t = 0; m_active = 0; m_adp = 0; m_shadow = 0; m_sdp = 0;
      m_pend = 0; m_fd = 0; m_an = 4'hf; m_dp = 1;
    end else begin
      s  = (m_t / 4) % 4;
      bl = blanked(s);
      m_an = bl ? 4'hf : ~(4'b0001 << s);
      m_dp = bl | ~m_adp[s];
      c = (m_t % 16) == 15 && (m_pend || load);
      m_fd = c;
      if (c) begin
        m_active = load ? din : m_shadow;
        m_adp    = load ? dp_in : m_sdp;
      end
      if (load) begin
        m_shadow = din;
        m_sdp    = dp_in;
      end
      m_pend = c ? 1'b0 : (load ? 1'b1 : m_pend);
      m_t++;
    end
  end

  task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0d", name, got, exp, m_t);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) if (go) begin
    chk("addr", 16'(addr), 16'((m_active >> (4 * ((m_t / 4) % 4))) & 16'hf));
    chk("an", 16'(an), 16'(m_an));
    chk("dp", 16'(dp), 16'(m_dp));
    chk("pending", 16'(pending), 16'(m_pend));
    chk("frame_done", 16'(frame_done), 16'(m_fd));
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_t(int v);
    int n = 0;
    while ((m_t % 16) != v && n < 40) begin
      tick(1);
      n++;
    end
    if ((m_t % 16) != v) begin
      errors++;
      $display("FAIL wait_t timeout got=%0d exp=%0d", m_t % 16, v);
    end
  endtask

  initial begin
    tick(2);
    chk("rst_an", 16'(an), 16'hf);
    chk("rst_dp", 16'(dp), 16'h1);
    chk("rst_addr", 16'(addr), 16'h0);
    chk("rst_pend", 16'(pending), 16'h0);
    chk("rst_fd", 16'(frame_done), 16'h0);
    reset = 0;
    tick(1);
    chk("scan0_an", 16'(an), 16'he);
    tick(4);
    chk("scan1_an", 16'(an), 16'hd);
    // load 1234 during slot 1
    wait_t(4);
    din = 16'h1234; load = 1;
    tick(1);
    load = 0;
    chk("l_pend", 16'(pending), 16'h1);
    chk("l_addr_old", 16'(addr), 16'h0);
    wait_t(0);
    chk("l_fd", 16'(frame_done), 16'h1);
    chk("l_pend0", 16'(pending), 16'h0);
    chk("l_addr4", 16'(addr), 16'h4);
    chk("l_an_prev", 16'(an), 16'h7);
    tick(1);
    chk("l_fd0", 16'(frame_done), 16'h0);
    chk("l_an0", 16'(an), 16'he);
    wait_t(4);
    chk("l_addr3", 16'(addr), 16'h3);
    tick(1);
    chk("l_an1", 16'(an), 16'hd);
    // leading-zero blanking of 0050
    wait_t(2);
    blank_lz = 1; din = 16'h0050; load = 1;
    tick(1);
    load = 0;
    wait_t(1);
    chk("z_an0", 16'(an), 16'he);
    wait_t(5);
    chk("z_an1", 16'(an), 16'hd);
    chk("z_addr", 16'(addr), 16'h5);
    wait_t(9);
    chk("z_an2", 16'(an), 16'hf);
    wait_t(13);
    chk("z_an3", 16'(an), 16'hf);
    blank_lz = 0;
    tick(16);
    chk("z_an3_lit", 16'(an), 16'h7);
    // all-zero value with decimal point on digit 0
    blank_lz = 1; din = 16'h0000; dp_in = 4'b0001; load = 1;
    tick(1);
    load = 0;
    wait_t(1);
    chk("d_an0", 16'(an), 16'he);
    chk("d_dp0", 16'(dp), 16'h0);
    wait_t(5);
    chk("d_an1", 16'(an), 16'hf);
    chk("d_dp1", 16'(dp), 16'h1);
    // load exactly on the boundary cycle
    blank_lz = 0; dp_in = 0;
    wait_t(15);
    din = 16'habcd; load = 1;
    tick(1);
    load = 0;
    chk("b_fd", 16'(frame_done), 16'h1);
    chk("b_pend", 16'(pending), 16'h0);
    chk("b_addr_d", 16'(addr), 16'hd);
    tick(1);
    chk("b_fd0", 16'(frame_done), 16'h0);
    wait_t(4);
    chk("b_addr_c", 16'(addr), 16'hc);
    wait_t(12);
    chk("b_addr_a", 16'(addr), 16'ha);
    // two loads then reset before the boundary
    wait_t(2);
    din = 16'h1111; load = 1;
    tick(1);
    load = 0;
    wait_t(5);
    din = 16'h2222; load = 1;
    tick(1);
    load = 0;
    wait_t(8);
    reset = 1;
    tick(1);
    chk("r_an", 16'(an), 16'hf);
    chk("r_dp", 16'(dp), 16'h1);
    chk("r_pend", 16'(pending), 16'h0);
    chk("r_addr", 16'(addr), 16'h0);
    reset = 0;
    tick(20);
    chk("r_addr_after", 16'(addr), 16'h0);
    chk("r_pend_after", 16'(pending), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
